timer_arbiter: RTL and testbench
================================

# timer_arbiter

Shares one overflow-style up-counter among `N_REQ` requesters, each asking for a timeout of its own length. The block arbitrates between pending requests, grants the counter to one requester, and runs it to that requester's limit. It then pulses a per-requester done flag. It sits between the control FSMs that need delays and the single timer resource, so the design does not need one counter per client.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `COUNTER_BITS`, default 32: width of the counter and of each limit.

Ports:
- `i_CLK` input 1: clock; all logic acts on the rising edge.
- `i_RST_N` input 1: reset, synchronous and active-low.
- `i_REQ` input `N_REQ`: per-requester request level; held high until done or until withdrawn.
- `i_LIM` input `N_REQ*COUNTER_BITS`: packed limits; requester k uses bits `[k*COUNTER_BITS +: COUNTER_BITS]`.
- `o_GNT` output `N_REQ`: one-hot grant; high while that requester owns the counter.
- `o_DONE` output `N_REQ`: one-cycle pulse on the requester whose timeout expired.
- `o_BUSY` output 1: high in RUN and DONE.
- `o_COUNT` output `COUNTER_BITS`: current count; 0 when not in RUN/DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE. All outputs are registered.
- **IDLE**
  - If `i_REQ != 0`, choose a winner w and latch `lim = i_LIM[w]`.
  - If the latched `lim == 0`, store it as 1 instead.
  - Set `o_GNT = 1<<w`, `o_COUNT = 0`, and go to RUN.
  - If no request is pending, stay in IDLE.
- **RUN**
  - `o_COUNT` increments by 1 each cycle.
  - When the incremented value equals `lim`, go to DONE.
  - If `i_REQ[w]` is low in any RUN cycle, abort:
    - Go to IDLE next cycle with `o_GNT = 0` and `o_COUNT = 0`.
    - `o_DONE` is not pulsed.
    - The arbitration pointer still advances past w.
- **DONE**
  - `o_DONE = 1<<w` for exactly this cycle.
  - `o_GNT = 0`, and `o_COUNT` holds `lim`.
  - The arbitration pointer is set to w. Next state is IDLE.
- **Arbitration (default)**: round-robin. Search starts at `(ptr+1) mod N_REQ` and the first set `i_REQ` bit wins.
- Changes to `i_LIM[w]` after latching are ignored until the next grant.
- Counter width rule: `o_COUNT` never exceeds `lim`, so no wrap-around is possible.
- Requests from non-granted requesters during RUN/DONE are only sampled at the next IDLE. There is no queueing beyond the level of `i_REQ`.

## Timing
- Reset (`i_RST_N` low at a clock edge) gives the following values next cycle:
  - state IDLE
  - `o_GNT = 0`, `o_DONE = 0`, `o_BUSY = 0`, `o_COUNT = 0`
  - `ptr = N_REQ-1`, so requester 0 has first priority.
- Reset takes effect in any state, including mid-RUN. No `o_DONE` is emitted for a timer cut short by reset.
- Grant latency, for a request sampled in IDLE at edge t:
  - `o_GNT` and `o_BUSY` go high after edge t.
  - Cycle t+k of RUN shows `o_COUNT = k-1`.
- Timeout length: with effective limit L, `o_GNT` is high for exactly L cycles, and `o_DONE` is high in the cycle right after the last grant cycle.
- Back-to-back throughput: after a DONE cycle, the earliest next grant is 2 cycles later (DONE → IDLE → RUN).
- Simultaneous events:
  - Withdrawal of `i_REQ[w]` in the same cycle RUN reaches the limit: the abort wins, so there is no DONE.
  - Several requests in the same IDLE cycle: exactly one is granted, per the arbitration rule.

## Configuration
- `TIMER_ARBITER_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest set index of `i_REQ` always wins, and `ptr` is unused.
  - Undefined: round-robin as described in Operation.
  - All other behaviour and timing are identical in both builds.

## Test plan
- Single request, `N_REQ=4`:
  - Stimulus: `i_REQ=4'b0010` with `lim[1]=5` from reset.
  - Required: `o_GNT=4'b0010` for 5 cycles while `o_COUNT` runs 0..4, then `o_DONE=4'b0010` for 1 cycle with `o_COUNT=5`, then back to IDLE.
- Round-robin:
  - Stimulus: `i_REQ=4'b1001` held continuously, all limits 2.
  - Required: grants alternate 0, 3, 0, 3. Each `o_DONE` pulse is followed 2 cycles later by the next grant.
- Fixed priority (build with `TIMER_ARBITER_FIXED_PRIO_EN`):
  - Stimulus: the same `4'b1001` stimulus.
  - Required: requester 0 is granted every time, and requester 3 is never granted.
- Abort:
  - Stimulus: grant requester 2 with `lim=10`, then drop `i_REQ[2]` in RUN cycle 4.
  - Required: `o_GNT=0` and `o_COUNT=0` next cycle, with no `o_DONE` pulse.
- Zero limit:
  - Stimulus: `lim[0]=0`.
  - Required: 1 grant cycle, then an `o_DONE[0]` pulse with `o_COUNT=1`.
- Reset mid-run:
  - Stimulus: `i_RST_N` low for 1 edge during RUN at `o_COUNT=3`.
  - Required: next cycle all outputs are 0. With requesters 0 and 1 pending, the next grant goes to requester 0.

Source files
------------

// File: rtl/timer_arbiter.sv
// Shared timeout counter: arbitrates N_REQ requesters onto one up-counter and pulses done per owner.
// Define TIMER_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module timer_arbiter #(
    parameter int N_REQ        = 4,
    parameter int COUNTER_BITS = 32
) (
    input  logic                          i_CLK,
    input  logic                          i_RST_N,
    input  logic [N_REQ-1:0]              i_REQ,
    input  logic [N_REQ*COUNTER_BITS-1:0] i_LIM,
    output logic [N_REQ-1:0]              o_GNT,
    output logic [N_REQ-1:0]              o_DONE,
    output logic                          o_BUSY,
    output logic [COUNTER_BITS-1:0]       o_COUNT
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        own;
    logic [COUNTER_BITS-1:0] lim;
    logic [COUNTER_BITS-1:0] win_lim;
    logic [COUNTER_BITS-1:0] count_nxt;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_vld;

`ifdef TIMER_ARBITER_FIXED_PRIO_EN
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_REQ[IDX_W'(i)]) begin
                win_idx = IDX_W'(i);
                win_vld = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr;

    // Scan farthest-first so the nearest requester after ptr is the last assignment.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (i_REQ[IDX_W'(j)]) begin
                win_idx = IDX_W'(j);
                win_vld = 1'b1;
            end
        end
    end

    // Pointer parks on the last owner whether it finished or aborted.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N)
            ptr <= IDX_W'(N_REQ - 1);
        else if ((state == S_RUN && !i_REQ[own]) || state == S_DONE)
            ptr <= own;
    end
`endif

    assign win_lim   = i_LIM[int'(win_idx)*COUNTER_BITS +: COUNTER_BITS];
    assign count_nxt = o_COUNT + COUNTER_BITS'(1);

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state   <= S_IDLE;
            own     <= '0;
            lim     <= '0;
            o_GNT   <= '0;
            o_DONE  <= '0;
            o_BUSY  <= 1'b0;
            o_COUNT <= '0;
        end else begin
            o_DONE <= '0;
            case (state)
                S_IDLE: begin
                    o_COUNT <= '0;
                    if (win_vld) begin
                        state  <= S_RUN;
                        own    <= win_idx;
                        lim    <= (win_lim == '0) ? COUNTER_BITS'(1) : win_lim;
                        o_GNT  <= N_REQ'(1) << win_idx;
                        o_BUSY <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Withdrawal beats reaching the limit in the same cycle.
                    if (!i_REQ[own]) begin
                        state   <= S_IDLE;
                        o_GNT   <= '0;
                        o_BUSY  <= 1'b0;
                        o_COUNT <= '0;
                    end else if (count_nxt == lim) begin
                        state   <= S_DONE;
                        o_GNT   <= '0;
                        o_DONE  <= N_REQ'(1) << own;
                        o_COUNT <= count_nxt;
                    end else begin
                        o_COUNT <= count_nxt;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    o_BUSY  <= 1'b0;
                    o_COUNT <= '0;
                end
                default: begin
                    state   <= S_IDLE;
                    o_GNT   <= '0;
                    o_BUSY  <= 1'b0;
                    o_COUNT <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter (N_REQ=4, 32-bit counter) with hand-computed expectations.
module tb_timer_arbiter;

    logic             i_CLK = 1'b0;
    logic             i_RST_N;
    logic [3:0]       i_REQ;
    logic [3:0][31:0] lim;
    logic [127:0]     i_LIM;
    logic [3:0]       o_GNT;
    logic [3:0]       o_DONE;
    logic             o_BUSY;
    logic [31:0]      o_COUNT;

    int n_chk  = 0;
    int n_fail = 0;

    assign i_LIM = lim;

    timer_arbiter #(.N_REQ(4), .COUNTER_BITS(32)) dut (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_REQ   (i_REQ),
        .i_LIM   (i_LIM),
        .o_GNT   (o_GNT),
        .o_DONE  (o_DONE),
        .o_BUSY  (o_BUSY),
        .o_COUNT (o_COUNT)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic do_reset();
        i_RST_N = 1'b0;
        tick();
        i_RST_N = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},   32'(o_GNT),  32'h0);
        check({tag, "_done"},  32'(o_DONE), 32'h0);
        check({tag, "_busy"},  32'(o_BUSY), 32'h0);
        check({tag, "_count"}, o_COUNT,     32'h0);
    endtask

    logic [3:0] exp_gnt;

    initial begin
        i_RST_N = 1'b0;
        i_REQ   = '0;
        lim     = '0;

        // Reset state
        do_reset();
        check_idle("reset");

        // Single request, lim=5; a late limit change must be ignored
        lim[1] = 32'd5;
        i_REQ  = 4'b0010;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("single_gnt",   32'(o_GNT),  32'h2);
            check("single_busy",  32'(o_BUSY), 32'h1);
            check("single_count", o_COUNT,     32'(k));
            if (k == 1) lim[1] = 32'd2;
            tick();
        end
        check("single_done",      32'(o_DONE), 32'h2);
        check("single_done_gnt",  32'(o_GNT),  32'h0);
        check("single_done_cnt",  o_COUNT,     32'd5);
        check("single_done_busy", 32'(o_BUSY), 32'h1);
        i_REQ = '0;
        tick();
        check_idle("single_after");

        // Two continuous requesters, all limits 2
        lim = {32'd2, 32'd2, 32'd2, 32'd2};
        i_REQ = 4'b1001;
        do_reset();
        check_idle("rr_reset");
        for (int g = 0; g < 4; g++) begin
`ifdef TIMER_ARBITER_FIXED_PRIO_EN
            exp_gnt = 4'b0001;
`else
            exp_gnt = (g % 2 == 1) ? 4'b1000 : 4'b0001;
`endif
            tick();
            check("rr_gnt0", 32'(o_GNT), 32'(exp_gnt));
            check("rr_cnt0", o_COUNT,    32'd0);
            tick();
            check("rr_gnt1", 32'(o_GNT), 32'(exp_gnt));
            check("rr_cnt1", o_COUNT,    32'd1);
            tick();
            check("rr_done",     32'(o_DONE), 32'(exp_gnt));
            check("rr_done_gnt", 32'(o_GNT),  32'h0);
            check("rr_done_cnt", o_COUNT,     32'd2);
            tick();
            check_idle("rr_gap");
        end

        // Abort in RUN cycle 4, then check the pointer moved past requester 2
        i_REQ = '0;
        lim[2] = 32'd10;
        do_reset();
        i_REQ = 4'b0100;
        tick();
        check("abort_gnt", 32'(o_GNT), 32'h4);
        tick();
        tick();
        tick();
        check("abort_cnt3", o_COUNT, 32'd3);
        i_REQ = 4'b0000;
        tick();
        check_idle("abort_next");
        i_REQ = 4'b1001;
        tick();
        check("abort_no_done", 32'(o_DONE), 32'h0);
`ifdef TIMER_ARBITER_FIXED_PRIO_EN
        check("abort_rr_gnt", 32'(o_GNT), 32'h1);
`else
        check("abort_rr_gnt", 32'(o_GNT), 32'h8);
`endif
        i_REQ = '0;
        tick();
        check_idle("abort_drop2");

        // Zero limit behaves as 1
        lim = '0;
        do_reset();
        i_REQ = 4'b0001;
        tick();
        check("zero_gnt", 32'(o_GNT), 32'h1);
        check("zero_cnt", o_COUNT,    32'd0);
        tick();
        check("zero_done",     32'(o_DONE), 32'h1);
        check("zero_done_gnt", 32'(o_GNT),  32'h0);
        check("zero_done_cnt", o_COUNT,     32'd1);
        i_REQ = '0;
        tick();
        check_idle("zero_after");

        // Reset mid-run; requester 1 owns first (ptr=0), then reset restores priority to 0
        lim = {32'd10, 32'd10, 32'd10, 32'd10};
        i_REQ = 4'b0011;
        tick();
`ifdef TIMER_ARBITER_FIXED_PRIO_EN
        check("mid_first_gnt", 32'(o_GNT), 32'h1);
`else
        check("mid_first_gnt", 32'(o_GNT), 32'h2);
`endif
        tick();
        tick();
        tick();
        check("mid_cnt3", o_COUNT, 32'd3);
        i_RST_N = 1'b0;
        tick();
        check_idle("mid_reset");
        i_RST_N = 1'b1;
        tick();
        check("mid_regrant", 32'(o_GNT), 32'h1);
        check("mid_cnt0",    o_COUNT,    32'd0);

        // Withdrawal on the same cycle the limit is reached: abort wins
        i_REQ = '0;
        lim[0] = 32'd2;
        do_reset();
        i_REQ = 4'b0001;
        tick();
        check("race_gnt", 32'(o_GNT), 32'h1);
        tick();
        check("race_cnt1", o_COUNT, 32'd1);
        i_REQ = '0;
        tick();
        check_idle("race_abort");
        tick();
        check_idle("race_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
